// File: rtl/switch_box_cfg_loader_pkg.sv
// Shared constants for the switch box config loader.
// Select encodings, FSM state codes and reset config.
package switch_box_cfg_loader_pkg;

  localparam int CFG_W = 8;

  localparam logic [CFG_W-1:0] RESET_CFG = 8'hFF;

  // Per-output 2-bit select; 2'b11 ties the output low
  localparam logic [1:0] SEL_N_FROM_E = 2'b00;
  localparam logic [1:0] SEL_N_FROM_S = 2'b01;
  localparam logic [1:0] SEL_N_FROM_W = 2'b10;
  localparam logic [1:0] SEL_E_FROM_N = 2'b00;
  localparam logic [1:0] SEL_E_FROM_S = 2'b01;
  localparam logic [1:0] SEL_E_FROM_W = 2'b10;
  localparam logic [1:0] SEL_S_FROM_N = 2'b00;
  localparam logic [1:0] SEL_S_FROM_E = 2'b01;
  localparam logic [1:0] SEL_S_FROM_W = 2'b10;
  localparam logic [1:0] SEL_W_FROM_N = 2'b00;
  localparam logic [1:0] SEL_W_FROM_E = 2'b01;
  localparam logic [1:0] SEL_W_FROM_S = 2'b10;
  localparam logic [1:0] SEL_ZERO     = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_HDR_ADDR = 3'd0;
  localparam state_t S_HDR_CNT  = 3'd1;
  localparam state_t S_DATA     = 3'd2;
  localparam state_t S_DRAIN    = 3'd3;
  localparam state_t S_COMMIT   = 3'd4;

endpackage

// File: rtl/switch_box_cfg_loader_cfg_shadow_bank.sv
// Shadow and active config registers per switch box element.
// Active copies the whole shadow bank in one cycle on commit.
module switch_box_cfg_loader_cfg_shadow_bank
  import switch_box_cfg_loader_pkg::*;
#(
  parameter int               NUM_ELEM = 4,
  parameter logic [CFG_W-1:0] CFG_RST  = RESET_CFG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [7:0]                idx,
  input  logic [CFG_W-1:0]          wdata,
  input  logic                      commit,
  output logic [NUM_ELEM*CFG_W-1:0] act_flat
);

  logic [CFG_W-1:0] sh_q  [NUM_ELEM];
  logic [CFG_W-1:0] sh_d  [NUM_ELEM];
  logic [CFG_W-1:0] act_q [NUM_ELEM];
  logic [CFG_W-1:0] act_d [NUM_ELEM];

  always_comb begin
    for (int i = 0; i < NUM_ELEM; i++) begin
      sh_d[i]  = sh_q[i];
      act_d[i] = act_q[i];
      if (we && idx == 8'(i)) begin
        sh_d[i] = wdata;
      end
      if (commit) begin
        act_d[i] = sh_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        sh_q[i]  <= CFG_RST;
        act_q[i] <= CFG_RST;
      end
    end else begin
      sh_q  <= sh_d;
      act_q <= act_d;
    end
  end

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_flat
    assign act_flat[g*CFG_W +: CFG_W] = act_q[g];
  end

endmodule

// File: rtl/switch_box_cfg_loader.sv
// Byte-stream config loader for a row of switch box elements.
// Frame = start index, count, data bytes; commits atomically.
module switch_box_cfg_loader
  import switch_box_cfg_loader_pkg::*;
#(
  parameter int               NUM_ELEM = 4,
  parameter logic [CFG_W-1:0] CFG_RST  = RESET_CFG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic [7:0]                cfg_data,
  output logic                      cfg_ready,
  output logic [NUM_ELEM*CFG_W-1:0] c_out,
  output logic                      commit,
  output logic                      busy,
  output logic                      err
);

  localparam logic [8:0] LIMIT = 9'(NUM_ELEM);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ptr_q, ptr_d;
  logic       err_q, err_d;
  logic       acc;
  logic       we;
  logic [8:0] end_idx;

  assign cfg_ready = (state_q != S_COMMIT);
  assign acc       = cfg_valid & cfg_ready;
  assign commit    = (state_q == S_COMMIT);
  assign busy      = (state_q != S_HDR_ADDR);
  assign err       = err_q;
  // 9-bit sum so A+K cannot wrap past the element range
  assign end_idx   = {1'b0, addr_q} + {1'b0, cfg_data};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      S_HDR_ADDR: begin
        if (acc) begin
          addr_d  = cfg_data;
          state_d = S_HDR_CNT;
        end
      end
      S_HDR_CNT: begin
        if (acc) begin
          if (cfg_data == 8'd0) begin
            state_d = S_HDR_ADDR;
          end else if ({1'b0, addr_q} >= LIMIT
                       || end_idx > LIMIT) begin
            err_d   = 1'b1;
            cnt_d   = cfg_data;
            state_d = S_DRAIN;
          end else begin
            ptr_d   = addr_q;
            cnt_d   = cfg_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          we    = 1'b1;
          ptr_d = ptr_q + 8'd1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_DRAIN: begin
        if (acc) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_HDR_ADDR;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_HDR_ADDR;
      end
      default: begin
        state_d = S_HDR_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR_ADDR;
      addr_q  <= 8'd0;
      cnt_q   <= 8'd0;
      ptr_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  switch_box_cfg_loader_cfg_shadow_bank #(
    .NUM_ELEM (NUM_ELEM),
    .CFG_RST  (CFG_RST)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .idx      (ptr_q),
    .wdata    (cfg_data),
    .commit   (commit),
    .act_flat (c_out)
  );

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Scoreboard bench for switch_box_cfg_loader.
// Expected c_out queued at stimulus time, popped on commit.
module tb_switch_box_cfg_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cfg_ready;
  logic [31:0] c_out;
  logic        commit;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] sb[$];
  logic [7:0]  exp_sh[4];
  logic [31:0] exp_act;
  logic        exp_err;
  logic        cmt_seen = 1'b0;

  always #5 clk = ~clk;

  switch_box_cfg_loader #(
    .NUM_ELEM (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .c_out     (c_out),
    .commit    (commit),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Monitor: the cycle after a commit pulse, c_out must match queue head
  always @(negedge clk) begin
    if (rst) begin
      cmt_seen = 1'b0;
    end else begin
      if (cmt_seen) begin
        if (sb.size() == 0) chk("spurious_commit", 32'd1, 32'd0);
        else chk("c_out_commit", c_out, sb.pop_front());
      end
      cmt_seen = commit;
    end
  end

  function automatic logic [31:0] flat_sh();
    return {exp_sh[3], exp_sh[2], exp_sh[1], exp_sh[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_sh[i] = 8'hFF;
    exp_act = 32'hFFFF_FFFF;
    exp_err = 1'b0;
    sb.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] b);
    int tries;
    tries = 0;
    cfg_valid = 1'b1;
    cfg_data  = b;
    while (!cfg_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] k,
                       input bq_t d, input int gap);
    int  last;
    logic bad;
    last = d.size() - 1;
    bad  = (int'(a) >= 4) || (int'(a) + int'(k) > 4);
    send(a);
    idle(gap);
    send(k);
    if (k != 0 && bad) exp_err = 1'b1;
    for (int i = 0; i <= last; i++) begin
      idle(gap);
      if (i == last && k != 0 && !bad) begin
        if (gap > 0) chk("hold_mid_frame", c_out, exp_act);
        for (int j = 0; j < int'(k); j++) exp_sh[int'(a) + j] = d[j];
        exp_act = flat_sh();
        sb.push_back(exp_act);
      end
      send(d[i]);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_c_out", c_out, 32'hFFFF_FFFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_commit", {31'd0, commit}, 32'd0);

    // Full load, valid held
    frame(8'h00, 8'h04, '{8'h11, 8'h22, 8'h33, 8'h44}, 0);
    chk("full_commit_pulse", {31'd0, commit}, 32'd1);
    chk("full_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("full_c_out_old", c_out, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("full_c_out", c_out, 32'h4433_2211);
    chk("full_commit_end", {31'd0, commit}, 32'd0);
    chk("full_ready_back", {31'd0, cfg_ready}, 32'd1);

    // Partial load with 3 idle cycles between bytes
    frame(8'h02, 8'h01, '{8'hE4}, 3);
    idle(2);
    chk("partial_c_out", c_out, 32'h44E4_2211);

    // Out-of-range frame is drained, sets err, no commit
    frame(8'h03, 8'h02, '{8'hAA, 8'hBB}, 0);
    idle(2);
    chk("bad_err", {31'd0, err}, {31'd0, exp_err});
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_c_out", c_out, 32'h44E4_2211);
    frame(8'h00, 8'h01, '{8'h5A}, 0);
    idle(2);
    chk("after_bad_c_out", c_out, 32'h44E4_225A);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Start beyond element range
    frame(8'h04, 8'h01, '{8'h77}, 0);
    idle(2);
    chk("oob_start_c_out", c_out, exp_act);

    // Zero count
    send(8'h01);
    send(8'h00);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_commit", {31'd0, commit}, 32'd0);

    // Reset mid-frame
    send(8'h00);
    send(8'h04);
    send(8'h01);
    send(8'h02);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst_c_out", c_out, 32'hFFFF_FFFF);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    idle(2);
    chk("midrst_no_commit", c_out, 32'hFFFF_FFFF);
    frame(8'h00, 8'h04, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 0);
    idle(2);
    chk("reload_c_out", c_out, 32'hD4C3_B2A1);

    // Backpressure: next header presented during COMMIT
    frame(8'h00, 8'h02, '{8'h55, 8'h66}, 0);
    cfg_valid = 1'b1;
    cfg_data  = 8'h01;
    chk("bp_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("bp_in_commit", {31'd0, commit}, 32'd1);
    @(negedge clk);
    chk("bp_not_consumed", {31'd0, busy}, 32'd0);
    chk("bp_ready_high", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("bp_hdr_taken", {31'd0, busy}, 32'd1);
    chk("bp_c_out", c_out, 32'hD4C3_6655);
    send(8'h01);
    exp_sh[1] = 8'h77;
    exp_act = flat_sh();
    sb.push_back(exp_act);
    send(8'h77);
    idle(2);
    chk("bp_c_out2", c_out, 32'hD4C3_7755);
    chk("bp_err_clear", {31'd0, err}, 32'd0);

    idle(3);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
